mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory through an IDLE/ISSUE/WAIT/DONE sequence.
// Optional macro MEM_ARB_ROUND_ROBIN_EN alternates grants on conflict; otherwise data always wins.
module mem_port_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [63:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_xferByte,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [63:0] dm_rdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mem_xferByte,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);
    localparam logic       WIN_IF    = 1'b0;
    localparam logic       WIN_DM    = 1'b1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_winner_q, last_winner_d;
    logic [63:0] cmd_addr_q, cmd_addr_d;
    logic [63:0] cmd_wdata_q, cmd_wdata_d;
    logic        cmd_we_q, cmd_we_d;
    logic        cmd_byte_q, cmd_byte_d;
    logic [63:0] if_rdata_q, if_rdata_d;
    logic [63:0] dm_rdata_q, dm_rdata_d;

    logic arb_open;
    logic pick_dm;

    // Grants are only offered while out of reset and between transactions.
    always_comb begin
        arb_open = reset && ((state_q == IDLE) || (state_q == DONE));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_dm  = dm_req && (!if_req || (last_winner_q == WIN_IF));
`else
        pick_dm  = dm_req;
`endif
        if_gnt   = arb_open && if_req && !pick_dm;
        dm_gnt   = arb_open && pick_dm;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_winner_d = last_winner_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        cmd_we_d      = cmd_we_q;
        cmd_byte_d    = cmd_byte_q;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (dm_gnt) begin
                    state_d       = ISSUE;
                    last_winner_d = WIN_DM;
                    cmd_addr_d    = dm_addr;
                    cmd_wdata_d   = dm_wdata;
                    cmd_we_d      = dm_we;
                    cmd_byte_d    = dm_xferByte;
                end else if (if_gnt) begin
                    state_d       = ISSUE;
                    last_winner_d = WIN_IF;
                    cmd_addr_d    = if_addr;
                    cmd_wdata_d   = 64'd0;
                    cmd_we_d      = 1'b0;
                    cmd_byte_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = WAIT_INIT;
            end
            WAIT: begin
                // The last WAIT cycle is the one where memory data is valid.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (last_winner_q == WIN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!cmd_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_winner_q <= WIN_IF;
            cmd_addr_q    <= 64'd0;
            cmd_wdata_q   <= 64'd0;
            cmd_we_q      <= 1'b0;
            cmd_byte_q    <= 1'b0;
            if_rdata_q    <= 64'd0;
            dm_rdata_q    <= 64'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_winner_q <= last_winner_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_we_q      <= cmd_we_d;
            cmd_byte_q    <= cmd_byte_d;
            if_rdata_q    <= if_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
        end
    end

    assign mem_re       = (state_q == ISSUE) && !cmd_we_q;
    assign mem_we       = (state_q == ISSUE) && cmd_we_q;
    assign mem_xferByte = cmd_byte_q;
    assign mem_addr     = cmd_addr_q;
    assign mem_wdata    = cmd_wdata_q;
    assign if_valid     = (state_q == DONE) && (last_winner_q == WIN_IF);
    assign dm_valid     = (state_q == DONE) && (last_winner_q == WIN_DM);
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign busy         = (state_q != IDLE);

endmodule
